// File: rtl/bpred_pkg.sv
// Shared definitions for the branch history table.
//   - 2-bit saturating counter encodings and the allocate/init values.
//   - Default address-split widths and a default-width entry typedef.
//   - Sweep FSM state encodings.
// No ports (package).
package bpred_pkg;

  localparam int BPRED_PC_WIDTH    = 32;
  localparam int BPRED_INDEX_BITS  = 6;
  localparam int BPRED_OFFSET_BITS = 2;
  localparam int BPRED_TAG_WIDTH   = BPRED_PC_WIDTH - BPRED_INDEX_BITS - BPRED_OFFSET_BITS;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // New entries start weakly taken; swept entries start weakly not-taken.
  localparam ctr_t CTR_ALLOC = CTR_WT;
  localparam ctr_t CTR_INIT  = CTR_WNT;

  typedef struct packed {
    logic                       valid;
    logic [BPRED_TAG_WIDTH-1:0] tag;
    ctr_t                       ctr;
  } bpred_entry_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/bpred_sat_counter.sv
// Combinational next-value for a 2-bit saturating branch counter.
// Ports:
//   ctr      in  current counter
//   taken    in  resolved outcome
//   ctr_next out counter after training (saturates at CTR_ST / CTR_SNT)
module bpred_sat_counter
  import bpred_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor_table.sv
// Direct-mapped branch history table with registered lookup, single update
// port and an init/flush sweep FSM.
//
// Optional build macro: BPRED_UPDATE_BYPASS_EN
//   When defined, a lookup that lands on the same index as an update in the
//   same cycle sees the post-update entry. When undefined it sees the stored
//   (pre-update) entry.
//
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  synchronous active-low reset
//   lookup_req in  fetch wants a prediction this cycle
//   lookup_pc  in  PC being fetched
//   pred_valid out response for previous cycle's lookup_req
//   pred_taken out predicted taken (hit and counter MSB set)
//   pred_hit   out valid entry with matching tag
//   upd_valid  in  branch resolved this cycle
//   upd_pc     in  PC of resolved branch
//   upd_taken  in  resolved outcome
//   flush      in  one-cycle pulse, invalidate whole table
//   ready      out sweep finished, table live
//
// Handshake: lookup_req has no back-pressure; every lookup_req cycle yields
// exactly one pred_valid cycle one clock later. upd_valid is likewise
// fire-and-forget and is dropped while ready is low or flush is high.
module branch_predictor_table
  import bpred_pkg::*;
#(
  parameter int PC_WIDTH    = BPRED_PC_WIDTH,
  parameter int INDEX_BITS  = BPRED_INDEX_BITS,
  parameter int OFFSET_BITS = BPRED_OFFSET_BITS,
  parameter int TAG_WIDTH   = PC_WIDTH - INDEX_BITS - OFFSET_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lookup_req,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic                pred_hit,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic                flush,
  output logic                ready
);

  localparam int DEPTH = 1 << INDEX_BITS;

  // Entry layout follows bpred_entry_t but with this instance's tag width.
  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    ctr_t                 ctr;
  } entry_t;

  entry_t mem [DEPTH];

  // ---------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------
  state_t                fsm_state;
  state_t                state_d;
  logic [INDEX_BITS-1:0] ptr_q;
  logic [INDEX_BITS-1:0] ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_state <= ST_INIT;
      ptr_q     <= '0;
    end else begin
      fsm_state <= state_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    state_d = fsm_state;
    ptr_d   = ptr_q;
    unique case (fsm_state)
      ST_INIT: begin
        if (flush) begin
          ptr_d = '0;
        end else if (ptr_q == {INDEX_BITS{1'b1}}) begin
          // Last entry is written this cycle; table is live next cycle.
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        if (flush) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  assign ready = (fsm_state == ST_READY);

  // ---------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_WIDTH-1:0]  upd_tag;
  entry_t                upd_entry;
  logic                  upd_hit;
  logic                  upd_en;
  logic                  upd_we;
  ctr_t                  upd_ctr_next;
  entry_t                upd_wdata;

  assign upd_idx   = upd_pc[OFFSET_BITS +: INDEX_BITS];
  assign upd_tag   = upd_pc[PC_WIDTH-1 -: TAG_WIDTH];
  assign upd_entry = mem[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
  assign upd_en    = ready && upd_valid && !flush;
  // A not-taken miss does not allocate, so nothing is written.
  assign upd_we    = upd_en && (upd_hit || upd_taken);

  bpred_sat_counter u_upd_ctr (
    .ctr      (upd_entry.ctr),
    .taken    (upd_taken),
    .ctr_next (upd_ctr_next)
  );

  always_comb begin
    if (upd_hit) begin
      upd_wdata.valid = 1'b1;
      upd_wdata.tag   = upd_entry.tag;
      upd_wdata.ctr   = upd_ctr_next;
    end else begin
      upd_wdata.valid = 1'b1;
      upd_wdata.tag   = upd_tag;
      upd_wdata.ctr   = CTR_ALLOC;
    end
  end

  // ---------------------------------------------------------------------
  // Single write port: sweep has priority (updates are ignored in INIT)
  // ---------------------------------------------------------------------
  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_addr;
  entry_t                wr_data;

  always_comb begin
    wr_en         = 1'b0;
    wr_addr       = ptr_q;
    wr_data.valid = 1'b0;
    wr_data.tag   = '0;
    wr_data.ctr   = CTR_INIT;
    if (fsm_state == ST_INIT) begin
      wr_en = 1'b1;
    end else if (upd_we) begin
      wr_en   = 1'b1;
      wr_addr = upd_idx;
      wr_data = upd_wdata;
    end
  end

  // Storage carries no reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Lookup path
  // ---------------------------------------------------------------------
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]  lk_tag;
  entry_t                lk_entry;
  entry_t                lk_eff;
  logic                  lk_hit;

  assign lk_idx   = lookup_pc[OFFSET_BITS +: INDEX_BITS];
  assign lk_tag   = lookup_pc[PC_WIDTH-1 -: TAG_WIDTH];
  assign lk_entry = mem[lk_idx];

`ifdef BPRED_UPDATE_BYPASS_EN
  ctr_t byp_ctr_next;

  // Same index means the lookup reads the very entry being trained, so its
  // counter can be advanced locally instead of routing the write data.
  bpred_sat_counter u_byp_ctr (
    .ctr      (lk_entry.ctr),
    .taken    (upd_taken),
    .ctr_next (byp_ctr_next)
  );

  always_comb begin
    lk_eff = lk_entry;
    if (upd_we && (lk_idx == upd_idx)) begin
      if (upd_hit) begin
        lk_eff.ctr = byp_ctr_next;
      end else begin
        lk_eff.valid = 1'b1;
        lk_eff.tag   = upd_tag;
        lk_eff.ctr   = CTR_ALLOC;
      end
    end
  end
`else
  assign lk_eff = lk_entry;
`endif

  assign lk_hit = lk_eff.valid && (lk_eff.tag == lk_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= lookup_req;
      pred_hit   <= lookup_req && ready && lk_hit;
      pred_taken <= lookup_req && ready && lk_hit && lk_eff.ctr[1];
    end
  end

  // Offset bits are not part of the index or tag.
  logic unused_offset;
  assign unused_offset = ^{lookup_pc[OFFSET_BITS-1:0], upd_pc[OFFSET_BITS-1:0]};

endmodule

// File: tb/tb_branch_predictor_table.sv
// Self-checking bench for branch_predictor_table: directed scenarios then
// randomized traffic, compared against a table-of-arrays reference model.
module tb_branch_predictor_table;

  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        lookup_req;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        flush;
  logic        ready;

  branch_predictor_table dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_req (lookup_req),
    .lookup_pc  (lookup_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_hit   (pred_hit),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .flush      (flush),
    .ready      (ready)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit  m_valid [DEPTH];
  int  m_tag   [DEPTH];
  int  m_ctr   [DEPTH];
  int  init_left = DEPTH;
  bit  e_hit, e_taken;
  logic [3:0] exp_q[$];   // {pred_valid, pred_hit, pred_taken, ready}

  function automatic int pc_index(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic int pc_tag(input logic [31:0] pc);
    return int'(pc[31:8]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_lookup(input bit live);
    int li;
    li = pc_index(lookup_pc);
    e_hit   = lookup_req && live && m_valid[li] && (m_tag[li] == pc_tag(lookup_pc));
    e_taken = e_hit && (m_ctr[li] >= 2);
  endtask

  task automatic model_update(input bit live);
    int ui;
    if (upd_valid && live && !flush) begin
      ui = pc_index(upd_pc);
      if (m_valid[ui] && m_tag[ui] == pc_tag(upd_pc)) begin
        if (upd_taken) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
        else           m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
      end else if (upd_taken) begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = pc_tag(upd_pc);
        m_ctr[ui]   = 2;
      end
    end
  endtask

  // One clock: evaluate the model with the inputs present at the edge,
  // then compare DUT outputs shortly after the edge.
  task automatic tick();
    bit live;
    logic [3:0] e;
    @(posedge clk);
    live = (init_left == 0);
    if (!rst_n) begin
      e_hit = 1'b0;
      e_taken = 1'b0;
      init_left = DEPTH;
      model_clear();
      exp_q.push_back(4'b0000);
    end else begin
`ifdef BPRED_UPDATE_BYPASS_EN
      model_update(live);
      model_lookup(live);
`else
      model_lookup(live);
      model_update(live);
`endif
      if (flush) begin
        init_left = DEPTH;
        model_clear();
      end else if (init_left > 0) begin
        init_left--;
      end
      exp_q.push_back({lookup_req, e_hit, e_taken, init_left == 0});
    end
    #1;
    e = exp_q.pop_front();
    check("pred_valid", {31'd0, pred_valid}, {31'd0, e[3]});
    check("pred_hit",   {31'd0, pred_hit},   {31'd0, e[2]});
    check("pred_taken", {31'd0, pred_taken}, {31'd0, e[1]});
    check("ready",      {31'd0, ready},      {31'd0, e[0]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit lk, input logic [31:0] lpc,
                       input bit up, input logic [31:0] upc, input bit ut,
                       input bit fl);
    lookup_req = lk;
    lookup_pc  = lpc;
    upd_valid  = up;
    upd_pc     = upc;
    upd_taken  = ut;
    flush      = fl;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic look(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t);
    drive(1'b0, 32'h0, 1'b1, pc, t, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rpc_l, rpc_u;
    model_clear();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // Init sweep: ready low for 64 cycles, lookup mid-sweep misses.
    idle(5);
    look(32'h0000_1040);
    idle(57);
    check("ready_before_last", {31'd0, ready}, 32'd0);
    idle(1);
    check("ready_after_sweep", {31'd0, ready}, 32'd1);

    // Allocate and train down.
    upd(32'h0000_1040, 1'b1);
    look(32'h0000_1040);
    check("alloc_taken", {31'd0, pred_taken}, 32'd1);
    upd(32'h0000_1040, 1'b0);
    upd(32'h0000_1040, 1'b0);
    look(32'h0000_1040);
    upd(32'h0000_1040, 1'b0);
    look(32'h0000_1040);

    // Saturation high.
    for (int i = 0; i < 4; i++) upd(32'h0000_2000, 1'b1);
    look(32'h0000_2000);
    upd(32'h0000_2000, 1'b0);
    look(32'h0000_2000);
    check("sat_down_taken", {31'd0, pred_taken}, 32'd1);

    // Alias: same index, different tag.
    for (int i = 0; i < 3; i++) upd(32'h0000_1040, 1'b1);
    look(32'h0001_1040);
    check("alias_miss", {31'd0, pred_hit}, 32'd0);
    upd(32'h0001_1040, 1'b0);
    look(32'h0000_1040);
    check("alias_intact", {31'd0, pred_hit}, 32'd1);

    // Same-cycle collision at index 5.
    upd(32'h0000_0014, 1'b1);
    upd(32'h0000_0014, 1'b0);
    drive(1'b1, 32'h0000_0014, 1'b1, 32'h0000_0014, 1'b1, 1'b0);
`ifdef BPRED_UPDATE_BYPASS_EN
    check("collision", {31'd0, pred_taken}, 32'd1);
`else
    check("collision", {31'd0, pred_taken}, 32'd0);
`endif
    look(32'h0000_0014);
    check("collision_next", {31'd0, pred_taken}, 32'd1);

    // Flush in READY, with an update on the flush cycle (dropped).
    drive(1'b1, 32'h0000_2000, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    idle(63);
    check("flush_sweep_busy", {31'd0, ready}, 32'd0);
    idle(1);
    look(32'h0000_1040);
    look(32'h0000_2000);
    look(32'h0000_3000);

    // Flush at sweep cycle 30 restarts the sweep.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(30);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(64);

    // Reset at sweep cycle 10.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(10);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(64);

    // Randomized traffic on a small PC space so hits and aliases are common.
    for (int i = 0; i < 3000; i++) begin
      rpc_l = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      rpc_u = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 3) == 0) rpc_u = rpc_l;
      rst_n = ($urandom_range(0, 999) != 0);
      drive(1'($urandom_range(0, 1)), rpc_l,
            1'($urandom_range(0, 1)), rpc_u, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 299) == 0));
    end
    rst_n = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
